axi_read_arbiter: RTL and testbench

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

---
 rtl/axi_read_arbiter.sv | 156 +++++++++++++++
 tb/tb_axi_read_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Two-requester (inst/data) read arbiter onto one AXI read port, one transaction in flight.
// Data has priority; a saturating starve counter forces an inst grant after STARVE_LIMIT data wins.
module axi_read_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [2:0]  inst_size,
    input  logic [3:0]  inst_len,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic        inst_rlast,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [3:0]  data_len,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic        data_rlast,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    // state | meaning
    // IDLE  | no transaction; arbitrate and grant
    // ADDR  | arvalid high with latched fields until arready
    // DATA  | forward beats to owner until count reaches latched len
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    state_t      state, state_nxt;
    logic        own_data;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [3:0]  len_q;
    logic [3:0]  beat_cnt;
    logic [2:0]  starve_cnt;

    logic        grant;
    logic        pick_inst;
    logic        beat;
    logic        last_beat;

    // Termination is by beat count only; AXI rid/rresp/rlast are not consulted.
    logic        unused_rsignals;
    assign unused_rsignals = ^{rid, rresp, rlast};

    always_comb begin
        pick_inst = inst_req && (!data_req || (starve_cnt == STARVE_MAX));
        grant     = (state == IDLE) && (inst_req || data_req);
        beat      = (state == DATA) && rvalid;
        last_beat = beat && (beat_cnt == len_q);
    end

    always_comb begin
        state_nxt   = state;
        inst_gnt    = 1'b0;
        data_gnt    = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        inst_rvalid = 1'b0;
        inst_rlast  = 1'b0;
        inst_rdata  = 32'h0;
        data_rvalid = 1'b0;
        data_rlast  = 1'b0;
        data_rdata  = 32'h0;
        case (state)
            IDLE: begin
                if (grant) begin
                    inst_gnt  = pick_inst;
                    data_gnt  = !pick_inst;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = DATA;
            end
            DATA: begin
                rready = 1'b1;
                if (own_data) begin
                    data_rvalid = rvalid;
                    data_rlast  = last_beat;
                    data_rdata  = rdata;
                end else begin
                    inst_rvalid = rvalid;
                    inst_rlast  = last_beat;
                    inst_rdata  = rdata;
                end
                if (last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign arid    = {3'b000, own_data};
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 3'h0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            own_data   <= 1'b0;
            addr_q     <= 32'h0;
            size_q     <= 3'h0;
            len_q      <= 4'h0;
            beat_cnt   <= 4'h0;
            starve_cnt <= 3'h0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                own_data <= !pick_inst;
                addr_q   <= pick_inst ? inst_addr : data_addr;
                size_q   <= pick_inst ? inst_size : data_size;
                len_q    <= pick_inst ? inst_len  : data_len;
                if (pick_inst)
                    starve_cnt <= 3'h0;
                else if (inst_req && (starve_cnt != 3'h7))
                    starve_cnt <= starve_cnt + 3'h1;
            end
            if ((state == ADDR) && arready)
                beat_cnt <= 4'h0;
            else if (beat)
                beat_cnt <= beat_cnt + 4'h1;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: inputs driven 1ns after rising edge, outputs checked 4ns after.
module tb_axi_read_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req, data_req;
    logic [31:0] inst_addr, data_addr;
    logic [2:0]  inst_size, data_size;
    logic [3:0]  inst_len, data_len;
    logic        inst_gnt, inst_rvalid, inst_rlast;
    logic [31:0] inst_rdata;
    logic        data_gnt, data_rvalid, data_rlast;
    logic [31:0] data_rdata;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    axi_read_arbiter #(.STARVE_LIMIT(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size), .inst_len(inst_len),
        .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rlast(inst_rlast), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size), .data_len(data_len),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rlast(data_rlast), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    // Advance to 1ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #3;
    endtask

    // Run ADDR (arready=1) and DATA (rvalid every cycle) for one granted transaction; no checks.
    task automatic serve(input int len);
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        for (int b = 0; b <= len; b++) tick();
        rvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        inst_req = 0; data_req = 0; inst_addr = 0; data_addr = 0;
        inst_size = 0; data_size = 0; inst_len = 0; data_len = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        tick(); tick();
        settle();
        n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL reset_arvalid got=%b want=0", arvalid); end
        n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL reset_rready got=%b want=0", rready); end
        n_cmp++; if ({inst_gnt, data_gnt, inst_rvalid, data_rvalid} !== 4'b0)
            begin n_err++; $display("FAIL reset_gnt_rvalid got=%b want=0000", {inst_gnt, data_gnt, inst_rvalid, data_rvalid}); end
        n_cmp++; if (araddr !== 32'h0 || arlen !== 4'h0) begin n_err++; $display("FAIL reset_latched got=%h/%h want=0/0", araddr, arlen); end
        n_cmp++; if (arburst !== 2'b01 || arlock !== 2'b00 || arcache !== 4'h0 || arprot !== 3'h0)
            begin n_err++; $display("FAIL const_fields got=%b %b %h %h want=01 00 0 0", arburst, arlock, arcache, arprot); end
        tick();
        aresetn = 1'b1;
    endtask

    task automatic test_single_inst();
        tick();
        inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 3'd2; inst_len = 4'd0;
        settle();
        n_cmp++; if (inst_gnt !== 1'b1 || data_gnt !== 1'b0) begin n_err++; $display("FAIL single_gnt got=%b%b want=10", inst_gnt, data_gnt); end
        n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL single_arvalid_c0 got=%b want=0", arvalid); end
        tick();
        inst_req = 0; arready = 1;
        settle();
        n_cmp++; if (arvalid !== 1'b1 || arid !== 4'd0) begin n_err++; $display("FAIL single_ar got=%b/%h want=1/0", arvalid, arid); end
        n_cmp++; if (araddr !== 32'hBFC0_0000 || arlen !== 4'd0 || arsize !== 3'd2)
            begin n_err++; $display("FAIL single_arfields got=%h/%h/%h want=bfc00000/0/2", araddr, arlen, arsize); end
        n_cmp++; if (inst_gnt !== 1'b0) begin n_err++; $display("FAIL single_gnt_once got=%b want=0", inst_gnt); end
        tick();
        arready = 0; rvalid = 1; rdata = 32'h3C1D_0000; rid = 4'h7; rresp = 2'b10; rlast = 0;
        settle();
        n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL single_rready got=%b want=1", rready); end
        n_cmp++; if (inst_rvalid !== 1'b1 || inst_rlast !== 1'b1) begin n_err++; $display("FAIL single_beat got=%b%b want=11", inst_rvalid, inst_rlast); end
        n_cmp++; if (inst_rdata !== 32'h3C1D_0000) begin n_err++; $display("FAIL single_rdata got=%h want=3c1d0000", inst_rdata); end
        n_cmp++; if (data_rvalid !== 1'b0) begin n_err++; $display("FAIL single_nonowner got=%b want=0", data_rvalid); end
        tick();
        rvalid = 0; rid = 0; rresp = 0;
        settle();
        n_cmp++; if (rready !== 1'b0 || arvalid !== 1'b0) begin n_err++; $display("FAIL single_idle got=%b%b want=00", rready, arvalid); end
    endtask

    task automatic test_simultaneous();
        tick();
        inst_req = 1; inst_addr = 32'h0000_1000; inst_len = 0;
        data_req = 1; data_addr = 32'h8000_0040; data_len = 0; data_size = 3'd2;
        settle();
        n_cmp++; if (data_gnt !== 1'b1 || inst_gnt !== 1'b0) begin n_err++; $display("FAIL simul_first got=d%b i%b want=d1 i0", data_gnt, inst_gnt); end
        tick();
        data_req = 0; arready = 1;
        settle();
        n_cmp++; if (arid !== 4'd1 || araddr !== 32'h8000_0040) begin n_err++; $display("FAIL simul_arid got=%h/%h want=1/80000040", arid, araddr); end
        tick();
        arready = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; rlast = 1;
        settle();
        n_cmp++; if (data_rvalid !== 1'b1 || data_rlast !== 1'b1 || data_rdata !== 32'hDEAD_BEEF)
            begin n_err++; $display("FAIL simul_dbeat got=%b%b %h want=11 deadbeef", data_rvalid, data_rlast, data_rdata); end
        n_cmp++; if (inst_gnt !== 1'b0 || inst_rvalid !== 1'b0) begin n_err++; $display("FAIL simul_no_gnt_in_data got=%b%b want=00", inst_gnt, inst_rvalid); end
        tick();
        rvalid = 0; rlast = 0;
        settle();
        n_cmp++; if (inst_gnt !== 1'b1) begin n_err++; $display("FAIL simul_inst_next got=%b want=1", inst_gnt); end
        tick();
        inst_req = 0; arready = 1;
        settle();
        n_cmp++; if (arid !== 4'd0 || araddr !== 32'h0000_1000) begin n_err++; $display("FAIL simul_inst_ar got=%h/%h want=0/1000", arid, araddr); end
        tick();
        arready = 0; rvalid = 1;
        tick();
        rvalid = 0;
    endtask

    task automatic test_starvation();
        int who;
        tick();
        inst_req = 1; data_req = 1; inst_len = 0; data_len = 0;
        for (int g = 0; g < 5; g++) begin
            settle();
            who = inst_gnt ? 1 : (data_gnt ? 2 : 0);
            n_cmp++;
            if (g < 4 && who != 2) begin n_err++; $display("FAIL starve_grant%0d got=%0d want=2(data)", g, who); end
            else if (g == 4 && who != 1) begin n_err++; $display("FAIL starve_grant%0d got=%0d want=1(inst)", g, who); end
            if (g == 4) inst_req = 0;
            data_req = (g < 4);
            #1;
            serve(0);
            data_req = (g < 3);
            #0;
            if (g < 4) begin
                inst_req = 1;
                data_req = 1;
            end
        end
        inst_req = 0; data_req = 0;
    endtask

    task automatic test_burst();
        int beats, dv_pulses, dl_pulses;
        tick();
        data_req = 1; data_addr = 32'h0000_2000; data_len = 4'd3; data_size = 3'd2;
        settle();
        n_cmp++; if (data_gnt !== 1'b1) begin n_err++; $display("FAIL burst_gnt got=%b want=1", data_gnt); end
        tick();
        data_req = 0; data_addr = 32'hFFFF_FFFF; data_len = 4'hF; arready = 0;
        for (int w = 0; w < 2; w++) begin
            settle();
            n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'h0000_2000 || arlen !== 4'd3)
                begin n_err++; $display("FAIL burst_hold%0d got=%b %h %h want=1 00002000 3", w, arvalid, araddr, arlen); end
            tick();
        end
        arready = 1;
        tick();
        arready = 0;
        beats = 0; dv_pulses = 0; dl_pulses = 0;
        for (int i = 0; i < 7; i++) begin
            rvalid = (i % 2 == 0);
            rdata  = 32'hA000_0000 + i;
            rlast  = (i == 2);
            settle();
            if (data_rvalid === 1'b1) dv_pulses++;
            if (data_rlast === 1'b1) dl_pulses++;
            n_cmp++; if (data_rlast !== (rvalid && beats == 3))
                begin n_err++; $display("FAIL burst_rlast%0d got=%b want=%b", i, data_rlast, (rvalid && beats == 3)); end
            if (rvalid) beats++;
            tick();
        end
        rvalid = 0; rlast = 0;
        settle();
        n_cmp++; if (dv_pulses != 4) begin n_err++; $display("FAIL burst_pulses got=%0d want=4", dv_pulses); end
        n_cmp++; if (dl_pulses != 1) begin n_err++; $display("FAIL burst_rlast_count got=%0d want=1", dl_pulses); end
        n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL burst_end_idle got=%b want=0", rready); end
    endtask

    task automatic test_reset_mid();
        tick();
        data_req = 1; data_addr = 32'h0000_3000; data_len = 4'd3;
        tick();
        data_req = 0; arready = 1;
        tick();
        arready = 0; rvalid = 1;
        tick();
        tick();
        settle();
        n_cmp++; if (data_rvalid !== 1'b1 || data_rlast !== 1'b0) begin n_err++; $display("FAIL rstmid_pre got=%b%b want=10", data_rvalid, data_rlast); end
        aresetn = 0;
        #1;
        n_cmp++; if (rready !== 1'b0 || data_rvalid !== 1'b0 || arvalid !== 1'b0)
            begin n_err++; $display("FAIL rstmid_drop got=%b%b%b want=000", rready, data_rvalid, arvalid); end
        tick();
        aresetn = 1; rvalid = 0;
        tick();
        inst_req = 1; inst_addr = 32'h0000_4000; inst_len = 0;
        settle();
        n_cmp++; if (inst_gnt !== 1'b1) begin n_err++; $display("FAIL rstmid_regrant got=%b want=1", inst_gnt); end
        tick();
        inst_req = 0;
        settle();
        n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'h0000_4000 || arid !== 4'd0)
            begin n_err++; $display("FAIL rstmid_ar got=%b %h %h want=1 00004000 0", arvalid, araddr, arid); end
        serve_tail();
    endtask

    task automatic serve_tail();
        arready = 1;
        tick();
        arready = 0; rvalid = 1;
        tick();
        rvalid = 0;
    endtask

    initial begin
        test_reset();
        test_single_inst();
        test_simultaneous();
        test_starvation();
        test_burst();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
